mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips_pkg.sv | 19 +
 rtl/mdu_datapath.sv | 118 +++++++++++
 rtl/mult_div_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared ALU control codes and FSM state encoding for the multiply/divide unit.
package mips_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1111;
  localparam logic [3:0] ALU_DIV  = 4'b0011;

  localparam logic [1:0] S_IDLE_ENC = 2'b00;
  localparam logic [1:0] S_MUL_ENC  = 2'b01;
  localparam logic [1:0] S_DIV_ENC  = 2'b10;
  localparam logic [1:0] S_DONE_ENC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE_ENC,
    ST_MUL  = S_MUL_ENC,
    ST_DIV  = S_DIV_ENC,
    ST_DONE = S_DONE_ENC
  } state_t;

endpackage

// File: rtl/mdu_datapath.sv
// Operand/accumulator registers with one shift-add (mult) or restoring-subtract (div) step per cycle.
// Defining MULT_DIV_SIGNED_EN adds two's-complement magnitude handling and result sign fixup.
module mdu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo,
  output logic             o_div_zero
);

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_op;
  logic             r_is_div;
  logic             r_b_zero;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_sel;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH:0]   w_nacc;
  logic [WIDTH-1:0] w_nq;
  logic [WIDTH-1:0] w_load_a;
  logic [WIDTH-1:0] w_load_b;

`ifdef MULT_DIV_SIGNED_EN
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [2*WIDTH-1:0] w_prod;

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign w_load_a = absVal(i_a);
  assign w_load_b = absVal(i_b);
`else
  assign w_load_a = i_a;
  assign w_load_b = i_b;
`endif

  // The divide compare needs one spare bit beyond the shifted remainder to see its sign.
  assign w_sum     = r_acc + {1'b0, r_op};
  assign w_mul_sel = r_q[0] ? w_sum : r_acc;
  assign w_shift   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_op};

  always_comb begin
    w_nacc = r_acc;
    w_nq   = r_q;
    if (r_is_div) begin
      if (!w_diff[WIDTH+1]) begin
        w_nacc = w_diff[WIDTH:0];
        w_nq   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_nacc = w_shift;
        w_nq   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_nacc = {1'b0, w_mul_sel[WIDTH:1]};
      w_nq   = {w_mul_sel[0], r_q[WIDTH-1:1]};
    end
  end

`ifdef MULT_DIV_SIGNED_EN
  assign w_prod = r_neg_res ? (~{w_nacc[WIDTH-1:0], w_nq} + 1'b1) : {w_nacc[WIDTH-1:0], w_nq};

  always_comb begin
    o_next_hi = w_prod[2*WIDTH-1:WIDTH];
    o_next_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      o_next_hi = r_neg_rem ? (~w_nacc[WIDTH-1:0] + 1'b1) : w_nacc[WIDTH-1:0];
      o_next_lo = (r_neg_res && !r_b_zero) ? (~w_nq + 1'b1) : w_nq;
    end
  end
`else
  assign o_next_hi = w_nacc[WIDTH-1:0];
  assign o_next_lo = w_nq;
`endif

  assign o_div_zero = r_is_div & r_b_zero;

  // Mult keeps the multiplier in r_q and multiplicand in r_op; div keeps dividend in r_q, divisor in r_op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_op     <= '0;
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else if (i_load) begin
      r_acc    <= '0;
      r_q      <= i_is_div ? w_load_a : w_load_b;
      r_op     <= i_is_div ? w_load_b : w_load_a;
      r_is_div <= i_is_div;
      r_b_zero <= (i_b == '0);
`ifdef MULT_DIV_SIGNED_EN
      r_neg_res <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_neg_rem <= i_a[WIDTH-1];
`endif
    end else if (i_step) begin
      r_acc <= w_nacc;
      r_q   <= w_nq;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers; FSM and iteration counter live here.
// Macro MULT_DIV_SIGNED_EN selects two's-complement operands instead of unsigned.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;

  logic             w_accept_mul;
  logic             w_accept_div;
  logic             w_step;
  logic [WIDTH-1:0] w_next_hi;
  logic [WIDTH-1:0] w_next_lo;
  logic             w_div_zero;

  assign w_accept_mul = (r_state == ST_IDLE) && start && (alu_ctrl == ALU_MULT);
  assign w_accept_div = (r_state == ST_IDLE) && start && (alu_ctrl == ALU_DIV);
  assign w_step       = (r_state == ST_MUL) || (r_state == ST_DIV);

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept_mul | w_accept_div),
    .i_is_div   (w_accept_div),
    .i_step     (w_step),
    .i_a        (a),
    .i_b        (b),
    .o_next_hi  (w_next_hi),
    .o_next_lo  (w_next_lo),
    .o_div_zero (w_div_zero)
  );

  // The final step's result goes straight into hi/lo on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (w_accept_mul || w_accept_div) begin
            r_state  <= w_accept_div ? ST_DIV : ST_MUL;
            r_count  <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_count == LAST_COUNT) begin
            r_state  <= ST_DONE;
            hi       <= w_next_hi;
            lo       <= w_next_lo;
            done     <= 1'b1;
            div_zero <= w_div_zero;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
